icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller.
//  Fetcher word reads that hit are answered from local arrays; misses issue one 32-bit read to the
//  memory controller's fetcher port, fill the line, then answer. Read-only; no write path.
// PARAMETERS
//  INDEX_BITS  6   log2(number of lines); 64 lines of 32 bits
//  ADDR_WIDTH  32  fetch address width
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  rdy            in   1   global ready; low = freeze all state, outputs hold
//  flag_from_if   in   1   fetch request, level; held with addr_from_if until flag_to_if
//  addr_from_if   in   32  fetch address, word-aligned; bits[1:0] ignored
//  clear          in   1   pipeline flush (mispredict); kills pending answer
//  flag_to_if     out  1   one-cycle pulse: data_to_if valid
//  data_to_if     out  32  instruction word
//  flag_to_mem    out  1   miss read request, level; held until flag_from_mem
//  addr_to_mem    out  32  miss address, word-aligned ({tag,index,2'b00})
//  flag_from_mem  in   1   one-cycle pulse: data_from_mem valid
//  data_from_mem  in   32  filled word
// BEHAVIOUR
//  Reset (rst=0, async): all valid bits 0, state IDLE, flag_to_if=0, flag_to_mem=0,
//   data_to_if=0, addr_to_mem=0, drop=0. Data/tag arrays are not cleared.
//  Address split: index=addr[INDEX_BITS+1:2], tag=addr[ADDR_WIDTH-1:INDEX_BITS+2].
//  Lookup is combinational on addr_from_if; all outputs are registered.
//  IDLE: request accepted when flag_from_if=1, flag_to_if=0 (current cycle), clear=0.
//   Hit (valid[index] && tag match): next cycle flag_to_if=1, data_to_if=line; stay IDLE.
//   Hit latency 1 cycle.
//   Miss: next cycle flag_to_mem=1, addr_to_mem=word address; go MISS.
//  MISS: hold flag_to_mem/addr_to_mem. On flag_from_mem: write data/tag, set valid[index];
//   drop flag_to_mem next edge; go IDLE. If drop=0, flag_to_if=1 and
//   data_to_if=data_from_mem next cycle.
//   Miss latency = memory latency + 1.
//  The flag_to_if cycle never accepts: the fetcher drops or changes its request on seeing the pulse.
//   This prevents a double answer to a held request.
//  clear: in IDLE, suppresses acceptance that cycle and any same-cycle hit response.
//   In MISS, sets drop. The in-flight memory read still completes (memCtrl has no cancel),
//   the line is still filled, and no flag_to_if is issued. drop clears on return to IDLE.
//  clear coinciding with flag_from_mem: fill occurs, no response.
//  Fill into an occupied index overwrites unconditionally (no replacement choice).
//  flag_to_mem is never asserted in IDLE: at most one outstanding memory read.
//  rdy=0 at any point: no state, array or output change; response pulses stretch until rdy returns.
//  Reset mid-MISS: request is abandoned. memCtrl is reset by the same reset.
// STRUCTURE
//  Shared definitions: ADDR_TYPE, INT_TYPE, TRUE/FALSE, ZERO_WORD, ZERO_ADDR.
//  New shared defines: ICACHE_INDEX_BITS, ICACHE_TAG (tag slice range).
//  State encoding (IDLE=0, MISS=1) is local.
//  Sub-module icache_array: data and tag regs, plus the valid vector with async clear.
//   Has a combinational read port and a synchronous single write port.
//  FSM, drop flag and handshake registers live in icache.
// TESTING
//  1 Cold miss: addr 0x0000_0100, mem answers 0x0000_0013 after 5 cycles.
//    -> flag_to_mem=1 with addr_to_mem=0x100 from the next cycle; flag_to_if pulse, data 0x13,
//    1 cycle after flag_from_mem.
//  2 Re-fetch 0x100 -> flag_to_if next cycle with 0x13; flag_to_mem stays 0.
//  3 Conflict: fetch 0x200 (index 0, with 0x100 cached) -> miss.
//    Fill 0x0000_0093; refetch 0x100 -> miss again.
//  4 clear 2 cycles into miss at 0x300 -> fill completes, no flag_to_if.
//    Next fetch of 0x300 hits with the filled word.
//  5 Reset pulse mid-MISS, then fetch 0x100 -> miss (valid cleared); outputs 0 during reset.
//  6 rdy=0 for 3 cycles with a hit response pending -> flag_to_if held, delivered once rdy=1,
//    single answer per request.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
package icache_pkg;

    typedef logic [31:0] ADDR_TYPE;
    typedef logic [31:0] INT_TYPE;

    localparam logic     TRUE      = 1'b1;
    localparam logic     FALSE     = 1'b0;
    localparam INT_TYPE  ZERO_WORD = '0;
    localparam ADDR_TYPE ZERO_ADDR = '0;

    localparam int ICACHE_INDEX_BITS = 6;
    // Tag slice of a 32-bit fetch address: addr[ICACHE_TAG_HI:ICACHE_TAG_LO]
    localparam int ICACHE_TAG_HI     = 31;
    localparam int ICACHE_TAG_LO     = ICACHE_INDEX_BITS + 2;

endpackage

// File: rtl/icache_array.sv
// Line storage: data and tag arrays plus the valid vector, which alone is reset.
// Combinational read port, synchronous single write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_W      = ICACHE_TAG_HI - ICACHE_TAG_LO + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output INT_TYPE               rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  INT_TYPE               wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    INT_TYPE          data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[wr_idx] = TRUE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[wr_idx] <= wr_data;
            tag_q[wr_idx]  <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line read-only instruction cache between the
// fetcher and the memory controller; one outstanding memory read at most.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flag_from_if,
    input  logic [ADDR_WIDTH-1:0] addr_from_if,
    input  logic                  clear,
    output logic                  flag_to_if,
    output INT_TYPE               data_to_if,
    output logic                  flag_to_mem,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic                  flag_from_mem,
    input  INT_TYPE               data_from_mem
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_e;

    state_e                state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  flag_to_if_q, flag_to_if_d;
    INT_TYPE               data_to_if_q, data_to_if_d;
    logic                  flag_to_mem_q, flag_to_mem_d;
    logic [ADDR_WIDTH-1:0] addr_to_mem_q, addr_to_mem_d;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    INT_TYPE               rd_data;
    logic                  hit;
    logic                  fill_we;
    logic                  unused_lsb;

    assign unused_lsb = ^addr_from_if[1:0];

    icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (addr_from_if[INDEX_BITS+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (fill_we),
        .wr_idx  (addr_to_mem_q[INDEX_BITS+1:2]),
        .wr_tag  (addr_to_mem_q[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data (data_from_mem)
    );

    assign hit = rd_valid && (rd_tag == addr_from_if[ADDR_WIDTH-1:INDEX_BITS+2]);

    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        flag_to_if_d  = flag_to_if_q;
        data_to_if_d  = data_to_if_q;
        flag_to_mem_d = flag_to_mem_q;
        addr_to_mem_d = addr_to_mem_q;
        fill_we       = FALSE;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    flag_to_if_d = FALSE;
                    drop_d       = FALSE;
                    // The pulse cycle never accepts, so a held request is answered once.
                    if (flag_from_if && !flag_to_if_q && !clear) begin
                        if (hit) begin
                            flag_to_if_d = TRUE;
                            data_to_if_d = rd_data;
                        end else begin
                            flag_to_mem_d = TRUE;
                            addr_to_mem_d = {addr_from_if[ADDR_WIDTH-1:2], 2'b00};
                            state_d       = MISS;
                        end
                    end
                end
                MISS: begin
                    flag_to_if_d = FALSE;
                    if (clear) drop_d = TRUE;
                    // The memory read cannot be cancelled; the line is filled even when dropped.
                    if (flag_from_mem) begin
                        fill_we       = TRUE;
                        flag_to_mem_d = FALSE;
                        drop_d        = FALSE;
                        state_d       = IDLE;
                        if (!drop_q && !clear) begin
                            flag_to_if_d = TRUE;
                            data_to_if_d = data_from_mem;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            drop_q        <= FALSE;
            flag_to_if_q  <= FALSE;
            data_to_if_q  <= ZERO_WORD;
            flag_to_mem_q <= FALSE;
            addr_to_mem_q <= '0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            flag_to_if_q  <= flag_to_if_d;
            data_to_if_q  <= data_to_if_d;
            flag_to_mem_q <= flag_to_mem_d;
            addr_to_mem_q <= addr_to_mem_d;
        end
    end

    assign flag_to_if  = flag_to_if_q;
    assign data_to_if  = data_to_if_q;
    assign flag_to_mem = flag_to_mem_q;
    assign addr_to_mem = addr_to_mem_q;

endmodule

// File: tb/tb_icache.sv
// Directed plus random bench for icache against a line-level cache/memory model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flag_from_if = 1'b0;
    logic [31:0] addr_from_if = '0;
    logic        clear = 1'b0;
    logic        flag_to_if;
    logic [31:0] data_to_if;
    logic        flag_to_mem;
    logic [31:0] addr_to_mem;
    logic        flag_from_mem = 1'b0;
    logic [31:0] data_from_mem = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: per-line valid/tag/data
    bit          mv [64];
    logic [23:0] mt [64];
    logic [31:0] md [64];

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .flag_from_if(flag_from_if), .addr_from_if(addr_from_if), .clear(clear),
        .flag_to_if(flag_to_if), .data_to_if(data_to_if),
        .flag_to_mem(flag_to_mem), .addr_to_mem(addr_to_mem),
        .flag_from_mem(flag_from_mem), .data_from_mem(data_from_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h100) return 32'h0000_0013;
        if (w == 32'h200) return 32'h0000_0093;
        return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_quiet_if"}, {31'd0, flag_to_if}, 32'd0);
        chk({tag, "_quiet_mem"}, {31'd0, flag_to_mem}, 32'd0);
    endtask

    // One fetch, with a memory latency of lat cycles and an optional clear in miss cycle clr_at.
    task automatic fetch(input logic [31:0] a, input int lat, input int clr_at, input string nm);
        int          idx;
        logic [23:0] tg;
        logic [31:0] w;
        bit          dropped;
        idx = int'(a[7:2]);
        tg  = a[31:8];
        w   = memword(a);
        dropped = 0;
        flag_from_if = 1'b1;
        addr_from_if = a;
        @(negedge clk);
        if (mv[idx] && mt[idx] == tg) begin
            chk({nm, "_hit_flag"}, {31'd0, flag_to_if}, 32'd1);
            chk({nm, "_hit_data"}, data_to_if, md[idx]);
            chk({nm, "_hit_nomem"}, {31'd0, flag_to_mem}, 32'd0);
        end else begin
            chk({nm, "_req_flag"}, {31'd0, flag_to_mem}, 32'd1);
            chk({nm, "_req_addr"}, addr_to_mem, {a[31:2], 2'b00});
            chk({nm, "_req_noif"}, {31'd0, flag_to_if}, 32'd0);
            for (int c = 1; c <= lat; c++) begin
                if (c == lat) begin
                    flag_from_mem = 1'b1;
                    data_from_mem = w;
                end
                if (c == clr_at) begin
                    clear = 1'b1;
                    flag_from_if = 1'b0;
                    dropped = 1;
                end
                @(negedge clk);
                clear = 1'b0;
                flag_from_mem = 1'b0;
                data_from_mem = $urandom;
                if (c < lat) begin
                    chk({nm, "_hold_flag"}, {31'd0, flag_to_mem}, 32'd1);
                    chk({nm, "_hold_addr"}, addr_to_mem, {a[31:2], 2'b00});
                    chk({nm, "_hold_noif"}, {31'd0, flag_to_if}, 32'd0);
                end
            end
            chk({nm, "_fill_memoff"}, {31'd0, flag_to_mem}, 32'd0);
            chk({nm, "_fill_flag"}, {31'd0, flag_to_if}, dropped ? 32'd0 : 32'd1);
            if (!dropped) chk({nm, "_fill_data"}, data_to_if, w);
            mv[idx] = 1;
            mt[idx] = tg;
            md[idx] = w;
        end
        flag_from_if = 1'b0;
        @(negedge clk);
        chk_quiet({nm, "_after"});
    endtask

    // Request presented together with clear: must be ignored.
    task automatic idle_clear(input logic [31:0] a, input string nm);
        flag_from_if = 1'b1;
        addr_from_if = a;
        clear = 1'b1;
        @(negedge clk);
        chk_quiet(nm);
        clear = 1'b0;
        flag_from_if = 1'b0;
        @(negedge clk);
        chk_quiet({nm, "_next"});
    endtask

    initial begin
        logic [23:0] rtag;
        logic [5:0]  ridx;
        logic [1:0]  rlo;
        int          lat;
        int          clr;

        for (int i = 0; i < 64; i++) mv[i] = 0;

        #3;
        chk("rst_flag_to_if", {31'd0, flag_to_if}, 32'd0);
        chk("rst_data_to_if", data_to_if, 32'd0);
        chk("rst_flag_to_mem", {31'd0, flag_to_mem}, 32'd0);
        chk("rst_addr_to_mem", addr_to_mem, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        fetch(32'h0000_0100, 5, 0, "cold_miss");
        fetch(32'h0000_0100, 1, 0, "refetch_hit");
        fetch(32'h0000_0200, 3, 0, "conflict_miss");
        fetch(32'h0000_0102, 2, 0, "conflict_back");
        fetch(32'h0000_0300, 5, 2, "clear_in_miss");
        fetch(32'h0000_0300, 1, 0, "hit_after_drop");
        fetch(32'h0000_0400, 3, 3, "clear_with_fill");
        fetch(32'h0000_0400, 1, 0, "hit_after_coincide");
        fetch(32'hFFFF_FFFF, 1, 0, "top_addr_miss");
        fetch(32'hFFFF_FFFC, 1, 0, "top_addr_hit");
        idle_clear(32'h0000_0400, "idle_clear");

        // Reset while a miss is outstanding
        flag_from_if = 1'b1;
        addr_from_if = 32'h0000_0100;
        @(negedge clk);
        chk("rstmiss_req", {31'd0, flag_to_mem}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmiss_flag_to_mem", {31'd0, flag_to_mem}, 32'd0);
        chk("rstmiss_addr_to_mem", addr_to_mem, 32'd0);
        chk("rstmiss_flag_to_if", {31'd0, flag_to_if}, 32'd0);
        chk("rstmiss_data_to_if", data_to_if, 32'd0);
        flag_from_if = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mv[i] = 0;
        @(negedge clk);
        chk_quiet("post_reset");
        fetch(32'h0000_0300, 2, 0, "post_reset_300");
        fetch(32'h0000_0100, 4, 0, "post_reset_100");

        // rdy low with a hit pulse pending; request stays held throughout
        flag_from_if = 1'b1;
        addr_from_if = 32'h0000_0100;
        @(negedge clk);
        chk("stall_pulse", {31'd0, flag_to_if}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold_flag", {31'd0, flag_to_if}, 32'd1);
            chk("stall_hold_data", data_to_if, 32'h0000_0013);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("stall_single_answer", {31'd0, flag_to_if}, 32'd0);
        chk("stall_no_mem", {31'd0, flag_to_mem}, 32'd0);
        flag_from_if = 1'b0;
        @(negedge clk);

        // rdy low in IDLE: request must not be taken
        rdy = 1'b0;
        flag_from_if = 1'b1;
        addr_from_if = 32'h0000_0500;
        repeat (2) begin
            @(negedge clk);
            chk_quiet("frozen_idle");
        end
        rdy = 1'b1;
        flag_from_if = 1'b0;
        @(negedge clk);
        chk_quiet("unfrozen_idle");

        for (int n = 0; n < 60; n++) begin
            rtag = ($urandom_range(0, 5) == 0) ? 24'(($urandom)) : 24'($urandom_range(0, 3));
            ridx = 6'($urandom_range(0, 3));
            rlo  = 2'($urandom);
            lat  = $urandom_range(1, 4);
            clr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            if ($urandom_range(0, 7) == 0) idle_clear({rtag, ridx, rlo}, "rand_idle_clear");
            else                           fetch({rtag, ridx, rlo}, lat, clr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
